maq_encaixotamento: RTL
=======================

// Module: maq_encaixotamento
// PURPOSE
//  Boxing stage directly downstream of the fill/seal machine. Counts completed
//  bottles (rising edges of GC) into the box in position. Drives the box conveyor
//  to swap a full box for an empty one, and asserts BLOQ while no box can accept
//  bottles so upstream can hold. Keeps the fill count and a 2-digit BCD total of
//  finished boxes, and latches a fault on a swap timeout or a bottle overflow.
// PARAMETERS
//  BOX_SIZE      6      bottles per box; legal range 2..15
//  CNT_W         4      width of CNT_GARRAFAS; must hold BOX_SIZE-1
//  TROCA_TIMEOUT 5000   clk cycles allowed for one complete box swap
//  TMO_W         13     width of the timeout counter
// PORTS
//  clk           in   1      system clock, all logic on rising edge
//  reset         in   1      synchronous reset, active-high
//  ST            in   1      line enabled (start/stop switch)
//  GC            in   1      bottle complete, level from fill/seal stage
//  CX_OK         in   1      sensor: empty/partial box in filling position
//  M_CX          out  1      box conveyor motor
//  BLOQ          out  1      request upstream to stop delivering bottles
//  CNT_GARRAFAS  out  CNT_W  bottles in current box
//  CNT_CAIXAS    out  8      finished boxes, BCD {tens,units}, 00..99
//  CAIXA_CHEIA   out  1      1-cycle pulse when a box completes
//  FALHA         out  1      fault latched
// BEHAVIOUR
//  - All outputs are registered. Under reset: state=IDLE, every output 0,
//    pend=0, gc_d=0, timeout counter=0.
//  - Edge detect: rise = GC & ~gc_d. gc_d is updated every cycle, in every state.
//  - pend: a 1-bit store for one bottle that arrived while the box could not take
//    it.
//  - IDLE: M_CX=0, BLOQ=0, rises are ignored. When ST=1: go to ENCHENDO if CX_OK=1,
//    otherwise go to TROCA_ENTRA.
//  - ENCHENDO: M_CX=0.
//    - BLOQ = ~CX_OK.
//    - If CX_OK=1, inc = rise + pend (0..2) and pend is cleared.
//      - If cnt+inc >= BOX_SIZE: CNT_GARRAFAS<=0, the excess (0/1) goes to pend,
//        CAIXA_CHEIA<=1 for one cycle, CNT_CAIXAS increments in BCD (99 wraps to
//        00), go to TROCA_SAI.
//      - Otherwise CNT_GARRAFAS<=cnt+inc.
//    - If CX_OK=0 (box lost): a rise goes to pend, and the state is unchanged.
//  - TROCA_SAI: M_CX=1, BLOQ=1. Go to TROCA_ENTRA when CX_OK=0.
//  - TROCA_ENTRA: M_CX=1, BLOQ=1. Go to ENCHENDO when CX_OK=1. M_CX is 0 from the
//    first ENCHENDO cycle.
//  - Rises outside ENCHENDO-with-CX_OK=1 (IDLE excepted): set pend if pend=0. If
//    pend=1 already, this is overflow: go to FALHA.
//  - Timeout: the counter clears on entry to TROCA_SAI and increments each cycle
//    in TROCA_SAI/TROCA_ENTRA. When it reaches TROCA_TIMEOUT-1, go to FALHA.
//  - FALHA: FALHA=1, M_CX=0, BLOQ=1, counts frozen, rises ignored. Leave only on
//    ST=0 (to IDLE, FALHA<=0, pend<=0) or on reset.
//  - ST=0 in any state other than FALHA: go to IDLE next cycle with M_CX=0 and
//    BLOQ=0. CNT_GARRAFAS, CNT_CAIXAS and pend are held; only reset clears counts.
//  - Priority in a single cycle: reset > ST=0 > FALHA conditions > normal
//    transitions.
//  - Latency: a rise sampled at edge n updates CNT_GARRAFAS/CAIXA_CHEIA after
//    edge n+1.
// STRUCTURE
//  - Shared include maq_defs.vh: state encodings
//    (IDLE/ENCHENDO/TROCA_SAI/TROCA_ENTRA/FALHA, 3 bits) and the BCD width.
//  - Sub-module contador_bcd: one decade digit with
//    clk/reset/en in, q[3:0] and carry out. Two instances are chained for
//    CNT_CAIXAS.
//  - Remaining logic is one FSM always block plus the counters, all in this
//    module.
// TESTING
//  1. ST=1, CX_OK=1, 6 GC pulses -> CNT_GARRAFAS 1..5 then 0, one CAIXA_CHEIA
//     pulse, CNT_CAIXAS=8'h01, M_CX=1, BLOQ=1.
//  2. Swap: CX_OK 1->0 after 10 cycles, 0->1 after 20 more -> state ENCHENDO,
//     M_CX=0, BLOQ=0, FALHA=0.
//  3. During swap one GC pulse -> box starts at CNT_GARRAFAS=1. A second pulse in
//     the same swap -> FALHA=1, M_CX=0, BLOQ=1.
//  4. TROCA_TIMEOUT=50, CX_OK held 1 after box full -> FALHA=1 after 50 cycles.
//     Then ST=0 -> IDLE, FALHA=0, counts unchanged.
//  5. 100 boxes -> CNT_CAIXAS 8'h09->8'h10 carry checked, 8'h99->8'h00 wrap.
//  6. reset asserted mid-swap with GC high -> next cycle all outputs 0. GC still
//     high after reset produces no count until a new rising edge.

Source files
------------

// File: rtl/maq_encaixotamento_pkg.sv
// Shared definitions for the boxing stage: FSM state encoding and BCD digit width.
package maq_encaixotamento_pkg;

  typedef enum logic [2:0] {
    S_IDLE        = 3'd0,
    S_ENCHENDO    = 3'd1,
    S_TROCA_SAI   = 3'd2,
    S_TROCA_ENTRA = 3'd3,
    S_FALHA       = 3'd4
  } estado_t;

  localparam int BCD_W = 4;

endpackage

// File: rtl/maq_encaixotamento_contador_bcd.sv
// One decade BCD digit (0..9) with ripple carry for chaining decades.
module contador_bcd
  import maq_encaixotamento_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  output logic [BCD_W-1:0] q,
  output logic             carry
);

  localparam logic [BCD_W-1:0] NOVE = BCD_W'(9);

  // Carry is combinational so the next decade advances on the same edge.
  assign carry = en && (q == NOVE);

  always_ff @(posedge clk) begin
    if (reset) begin
      q <= '0;
    end else if (en) begin
      q <= carry ? '0 : q + BCD_W'(1);
    end
  end

endmodule

// File: rtl/maq_encaixotamento.sv
// Boxing stage: counts bottles into the current box, drives the box conveyor for
// swaps, holds upstream via BLOQ and latches faults on swap timeout or overflow.
module maq_encaixotamento
  import maq_encaixotamento_pkg::*;
#(
  parameter int BOX_SIZE      = 6,
  parameter int CNT_W         = 4,
  parameter int TROCA_TIMEOUT = 5000,
  parameter int TMO_W         = 13
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             ST,
  input  logic             GC,
  input  logic             CX_OK,
  output logic             M_CX,
  output logic             BLOQ,
  output logic [CNT_W-1:0] CNT_GARRAFAS,
  output logic [7:0]       CNT_CAIXAS,
  output logic             CAIXA_CHEIA,
  output logic             FALHA
);

  localparam logic [CNT_W:0]   BOX_LIM = (CNT_W+1)'(BOX_SIZE);
  localparam logic [TMO_W-1:0] TMO_LIM = TMO_W'(TROCA_TIMEOUT - 1);

  estado_t          state, state_n;
  logic             gc_d;
  logic             pend, pend_n;
  logic [TMO_W-1:0] tmo, tmo_n;
  logic [CNT_W-1:0] cnt_n;
  logic             m_cx_n, bloq_n, cheia_n, falha_n;
  logic             box_done;
  logic             rise;
  logic [CNT_W:0]   sum;

  logic [BCD_W-1:0] unid, dez;
  logic             carry_unid, carry_dez_unused;

  assign rise = GC & ~gc_d;

  always_comb begin
    state_n  = state;
    pend_n   = pend;
    tmo_n    = tmo;
    cnt_n    = CNT_GARRAFAS;
    cheia_n  = 1'b0;
    box_done = 1'b0;
    m_cx_n   = 1'b0;
    bloq_n   = 1'b0;
    falha_n  = 1'b0;
    sum      = {1'b0, CNT_GARRAFAS} + (CNT_W+1)'(rise) + (CNT_W+1)'(pend);

    if (!ST) begin
      // Stopping holds counts and pend; only leaving a fault discards pend.
      state_n = S_IDLE;
      if (state == S_FALHA) pend_n = 1'b0;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (CX_OK) begin
            state_n = S_ENCHENDO;
          end else begin
            state_n = S_TROCA_ENTRA;
            tmo_n   = '0;
          end
        end
        S_ENCHENDO: begin
          if (CX_OK) begin
            pend_n = 1'b0;
            if (sum >= BOX_LIM) begin
              cnt_n    = '0;
              pend_n   = (sum > BOX_LIM);
              cheia_n  = 1'b1;
              box_done = 1'b1;
              state_n  = S_TROCA_SAI;
              tmo_n    = '0;
            end else begin
              cnt_n = sum[CNT_W-1:0];
            end
          end else if (rise) begin
            if (pend) state_n = S_FALHA;
            else      pend_n  = 1'b1;
          end
        end
        S_TROCA_SAI, S_TROCA_ENTRA: begin
          if ((tmo == TMO_LIM) || (rise && pend)) begin
            state_n = S_FALHA;
          end else begin
            tmo_n = tmo + TMO_W'(1);
            if (rise) pend_n = 1'b1;
            if (state == S_TROCA_SAI && !CX_OK)  state_n = S_TROCA_ENTRA;
            if (state == S_TROCA_ENTRA && CX_OK) state_n = S_ENCHENDO;
          end
        end
        S_FALHA: ;
        default: state_n = S_IDLE;
      endcase
    end

    // Outputs are derived from the next state so they register alongside it.
    unique case (state_n)
      S_ENCHENDO:                 bloq_n = ~CX_OK;
      S_TROCA_SAI, S_TROCA_ENTRA: begin m_cx_n = 1'b1; bloq_n = 1'b1; end
      S_FALHA:                    begin bloq_n = 1'b1; falha_n = 1'b1; end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= S_IDLE;
      gc_d         <= 1'b0;
      pend         <= 1'b0;
      tmo          <= '0;
      CNT_GARRAFAS <= '0;
      M_CX         <= 1'b0;
      BLOQ         <= 1'b0;
      CAIXA_CHEIA  <= 1'b0;
      FALHA        <= 1'b0;
    end else begin
      state        <= state_n;
      gc_d         <= GC;
      pend         <= pend_n;
      tmo          <= tmo_n;
      CNT_GARRAFAS <= cnt_n;
      M_CX         <= m_cx_n;
      BLOQ         <= bloq_n;
      CAIXA_CHEIA  <= cheia_n;
      FALHA        <= falha_n;
    end
  end

  contador_bcd u_unid (
    .clk   (clk),
    .reset (reset),
    .en    (box_done),
    .q     (unid),
    .carry (carry_unid)
  );

  contador_bcd u_dez (
    .clk   (clk),
    .reset (reset),
    .en    (carry_unid),
    .q     (dez),
    .carry (carry_dez_unused)
  );

  assign CNT_CAIXAS = {dez, unid};

endmodule
